// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : mod_updown_counter
// Description : Modulo-N up/down counter with synchronous clamped load,
//               optional saturation at the limits, a combinational
//               terminal-count (cascade) output and sticky overflow/underflow
//               flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_updown_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  // Highest legal count value, and the modulus widened by one bit so it can
  // be compared against load_val even when MODULUS == 2^WIDTH.
  localparam logic [WIDTH-1:0] C_MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   C_MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;
  logic             r_unf;

  logic             w_at_max;
  logic             w_at_zero;
  logic             w_load_over;
  logic [WIDTH-1:0] w_load_clamped;
  logic [WIDTH-1:0] w_up_limit_next;
  logic [WIDTH-1:0] w_dn_limit_next;
  logic [WIDTH-1:0] w_count_next;
  logic             w_ovf_event;
  logic             w_unf_event;

  assign w_at_max       = (r_count == C_MAX_VAL);
  assign w_at_zero      = (r_count == '0);
  assign w_load_over    = ({1'b0, load_val} >= C_MOD_EXT);
  assign w_load_clamped = w_load_over ? C_MAX_VAL : load_val;

  // Value taken when a step is requested at a limit: hold in saturating
  // mode, wrap to the opposite limit otherwise.
  if (SATURATE != 0) begin : g_sat
    assign w_up_limit_next = C_MAX_VAL;
    assign w_dn_limit_next = '0;
  end else begin : g_wrap
    assign w_up_limit_next = '0;
    assign w_dn_limit_next = C_MAX_VAL;
  end

  // Terminal count: a step is about to happen at a limit. Reset and load
  // both pre-empt the step, so they suppress it.
  assign tc = enable && !load && !rst &&
              ((up_dn && w_at_max) || (!up_dn && w_at_zero));

  // Flag events are the terminal-count cycles, split by direction, so they
  // fire identically in wrap and saturate modes.
  assign w_ovf_event = tc && up_dn;
  assign w_unf_event = tc && !up_dn;

  // Next count value: load beats enable; no request means hold.
  always_comb begin
    w_count_next = r_count;
    if (load) begin
      w_count_next = w_load_clamped;
    end else if (enable) begin
      if (up_dn) begin
        w_count_next = w_at_max ? w_up_limit_next : r_count + 1'b1;
      end else begin
        w_count_next = w_at_zero ? w_dn_limit_next : r_count - 1'b1;
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  // Sticky flags: a set event on the same edge beats clr_flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_event || (r_ovf && !clr_flags);
      r_unf <= w_unf_event || (r_unf && !clr_flags);
    end
  end

  assign count = r_count;
  assign ovf   = r_ovf;
  assign unf   = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_updown_counter
// Description : Scoreboard bench for mod_updown_counter. Three instances:
//               0 = WIDTH 4, MODULUS 10, wrap; 1 = WIDTH 4, MODULUS 10,
//               saturate; 2 = WIDTH 4, MODULUS 16, wrap. Directed steps push
//               hand-computed expectations; a negedge monitor pops/compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] rst_s, en_s, up_s, ld_s, clr_s;
  logic [3:0] lv_s  [3];
  logic [3:0] cnt_s [3];
  logic [2:0] tc_s, ovf_s, unf_s;

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) u_dut0 (
    .clk(clk), .rst(rst_s[0]), .enable(en_s[0]), .up_dn(up_s[0]),
    .load(ld_s[0]), .load_val(lv_s[0]), .clr_flags(clr_s[0]),
    .count(cnt_s[0]), .tc(tc_s[0]), .ovf(ovf_s[0]), .unf(unf_s[0]));

  mod_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_dut1 (
    .clk(clk), .rst(rst_s[1]), .enable(en_s[1]), .up_dn(up_s[1]),
    .load(ld_s[1]), .load_val(lv_s[1]), .clr_flags(clr_s[1]),
    .count(cnt_s[1]), .tc(tc_s[1]), .ovf(ovf_s[1]), .unf(unf_s[1]));

  mod_updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(0)) u_dut2 (
    .clk(clk), .rst(rst_s[2]), .enable(en_s[2]), .up_dn(up_s[2]),
    .load(ld_s[2]), .load_val(lv_s[2]), .clr_flags(clr_s[2]),
    .count(cnt_s[2]), .tc(tc_s[2]), .ovf(ovf_s[2]), .unf(unf_s[2]));

  typedef struct {
    int         dut;
    logic [3:0] c;
    logic       t;
    logic       o;
    logic       u;
    string      nm;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Drive one cycle of inputs on one instance (others idle) and, if asked,
  // queue the outputs expected during that cycle.
  task automatic step(input int d, input logic r, input logic en, input logic up,
                      input logic ld, input logic [3:0] lv, input logic clr,
                      input logic [3:0] c, input logic t, input logic o,
                      input logic u, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_s = '0; en_s = '0; up_s = '0; ld_s = '0; clr_s = '0;
    for (int k = 0; k < 3; k++) lv_s[k] = '0;
    rst_s[d] = r; en_s[d] = en; up_s[d] = up; ld_s[d] = ld; clr_s[d] = clr;
    lv_s[d]  = lv;
    e.dut = d; e.c = c; e.t = t; e.o = o; e.u = u; e.nm = nm;
    sbq.push_back(e);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  always @(negedge clk) begin
    exp_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_tests++;
      if (cnt_s[e.dut] !== e.c || tc_s[e.dut] !== e.t ||
          ovf_s[e.dut] !== e.o || unf_s[e.dut] !== e.u) begin
        n_fail++;
        $display("FAIL %s (dut%0d): got count=%0d tc=%b ovf=%b unf=%b, expected count=%0d tc=%b ovf=%b unf=%b",
                 e.nm, e.dut, cnt_s[e.dut], tc_s[e.dut], ovf_s[e.dut], unf_s[e.dut],
                 e.c, e.t, e.o, e.u);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s = '0; en_s = '0; up_s = '0; ld_s = '0; clr_s = '0;
    for (int k = 0; k < 3; k++) lv_s[k] = '0;

    // Reset all instances together (state unknown before this edge).
    @(posedge clk);
    #1;
    rst_s = 3'b111;

    // ---------------- dut0: WIDTH 4, MODULUS 10, wrap ----------------
    // tc suppressed while rst even though enable/down at count 0.
    step(0, 1, 1, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, "reset_tc_low");
    for (int i = 0; i < 12; i++)
      step(0, 0, 1, 1, 0, 4'd0, 0, 4'(i % 10), (i == 9), (i >= 10), 0, "up_wrap_seq");
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'd2, 0, 1, 0, "clr_ovf");
    step(0, 0, 1, 1, 1, 4'd9, 0, 4'd2, 0, 0, 0, "load9_ovf_cleared");
    step(0, 0, 1, 1, 0, 4'd0, 1, 4'd9, 1, 0, 0, "up_at_max_with_clr");
    step(0, 0, 0, 0, 0, 4'd0, 1, 4'd0, 0, 1, 0, "set_beats_clr");
    step(0, 0, 1, 1, 1, 4'd13, 0, 4'd0, 0, 0, 0, "clr_alone");
    step(0, 0, 0, 0, 1, 4'd5, 0, 4'd9, 0, 0, 0, "load13_clamped");
    step(0, 0, 0, 0, 1, 4'd0, 0, 4'd5, 0, 0, 0, "load5");
    step(0, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 0, 0, "down_at_zero_tc");
    step(0, 0, 1, 0, 0, 4'd0, 0, 4'd9, 0, 0, 1, "down_wrap_unf");
    step(0, 0, 1, 1, 0, 4'd0, 0, 4'd8, 0, 0, 1, "dir_change_up");
    step(0, 0, 1, 0, 0, 4'd0, 0, 4'd9, 0, 0, 1, "dir_change_down");
    step(0, 0, 1, 0, 0, 4'd0, 0, 4'd8, 0, 0, 1, "down_step");
    step(0, 1, 1, 1, 1, 4'd3, 0, 4'd7, 0, 0, 1, "rst_with_load_at7");
    step(0, 0, 1, 1, 0, 4'd0, 0, 4'd0, 0, 0, 0, "after_rst");
    step(0, 0, 0, 0, 0, 4'd0, 0, 4'd1, 0, 0, 0, "resume_from_zero");

    // ---------------- dut1: WIDTH 4, MODULUS 10, saturate ----------------
    step(1, 0, 0, 0, 1, 4'd2, 0, 4'd0, 0, 0, 0, "sat_reset_state");
    step(1, 0, 1, 0, 0, 4'd0, 0, 4'd2, 0, 0, 0, "sat_down_2");
    step(1, 0, 1, 0, 0, 4'd0, 0, 4'd1, 0, 0, 0, "sat_down_1");
    step(1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 0, 0, "sat_down_0");
    step(1, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 0, 1, "sat_hold_0");
    step(1, 0, 0, 0, 1, 4'd9, 0, 4'd0, 0, 0, 1, "sat_held_idle");
    step(1, 0, 1, 1, 0, 4'd0, 0, 4'd9, 1, 0, 1, "sat_up_at_max");
    step(1, 0, 0, 0, 0, 4'd0, 0, 4'd9, 0, 1, 1, "sat_hold_max_ovf");

    // ---------------- dut2: WIDTH 4, MODULUS 16, wrap ----------------
    step(2, 0, 1, 0, 0, 4'd0, 0, 4'd0, 1, 0, 0, "m16_down_at_0");
    for (int i = 0; i < 3; i++)
      step(2, 0, 0, 0, 0, 4'd0, 0, 4'd15, 0, 0, 1, "m16_hold_15");
    step(2, 0, 1, 1, 0, 4'd0, 0, 4'd15, 1, 0, 1, "m16_up_at_15");
    step(2, 0, 0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 1, "m16_wrap_to_0");

    // Let the monitor drain the queue.
    @(posedge clk);
    @(posedge clk);
    #1;
    if (sbq.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_updown_counter.md
MOD_UPDOWN_COUNTER -- requirements
Module: mod_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the count register width in bits.
REQ-002 The block SHALL have parameter MODULUS, default 256, giving the count range 0..MODULUS-1; legal values 2 <= MODULUS <= 2^WIDTH.
REQ-003 The block SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-004 The block SHALL have port clk  input  1  clock, all state updated on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 The block SHALL have port enable  input  1  count enable.
REQ-007 The block SHALL have port up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-008 The block SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 The block SHALL have port load_val  input  WIDTH  value to load.
REQ-010 The block SHALL have port clr_flags  input  1  clear for the sticky ovf/unf flags.
REQ-011 The block SHALL have port count  output  WIDTH  registered count value.
REQ-012 The block SHALL have port tc  output  1  combinational terminal-count / cascade output.
REQ-013 The block SHALL have port ovf  output  1  registered sticky overflow flag.
REQ-014 The block SHALL have port unf  output  1  registered sticky underflow flag.

Function
REQ-015 Per-edge priority SHALL be: rst, then load, then enable; with none asserted, count holds.
REQ-016 On load, count SHALL take load_val next cycle, or MODULUS-1 if load_val >= MODULUS; enable and up_dn are ignored that cycle.
REQ-017 With enable=1, up_dn=1, count < MODULUS-1, count SHALL increment by 1 next cycle.
REQ-018 With enable=1, up_dn=0, count > 0, count SHALL decrement by 1 next cycle.
REQ-019 Up at MODULUS-1 SHALL give 0 next cycle when SATURATE=0 and hold MODULUS-1 when SATURATE=1.
REQ-020 Down at 0 SHALL give MODULUS-1 next cycle when SATURATE=0 and hold 0 when SATURATE=1.
REQ-021 Arithmetic SHALL be modulo MODULUS; count SHALL never exceed MODULUS-1, including when MODULUS < 2^WIDTH.
REQ-022 tc SHALL be 1 exactly when enable=1, load=0, rst=0, and (up_dn=1 with count=MODULUS-1 or up_dn=0 with count=0), in both modes.
REQ-023 ovf SHALL be set on the edge where an up-count step occurs at MODULUS-1 (the cycle tc=1 with up_dn=1), in both modes.
REQ-024 unf SHALL be set on the edge where a down-count step occurs at 0 (the cycle tc=1 with up_dn=0), in both modes.
REQ-025 clr_flags=1 SHALL clear ovf and unf next cycle; a set event on the same edge SHALL win over clr_flags for that flag.
REQ-026 A direction change between cycles SHALL take effect on the very next step, with no lost or extra counts.
REQ-027 Load SHALL NOT set or clear ovf/unf.

Reset
REQ-028 With rst=1 at a rising edge, count SHALL become 0 and ovf and unf SHALL become 0, overriding load, enable and clr_flags.
REQ-029 tc SHALL be 0 while rst=1.
REQ-030 Reset asserted mid-count SHALL abort the operation in progress; counting SHALL resume from 0 on the first edge after rst deasserts.

Verification (WIDTH=4, MODULUS=10 unless noted)
REQ-031 The bench SHALL cover: rst, then enable=1, up_dn=1 for 12 cycles -> count 0..9, 0, 1; tc=1 only at count=9; ovf=1 from the cycle after the 9->0 step.
REQ-032 The bench SHALL cover: SATURATE=1, load 2, then up_dn=0 for 4 cycles -> count 2, 1, 0, 0, 0; unf=1 after the first held step; tc=1 in each cycle with count=0.
REQ-033 The bench SHALL cover: load_val=13 with load=1 and enable=1 -> count=9, no ovf; load_val=5 -> count=5.
REQ-034 The bench SHALL cover: count=9, up, with clr_flags=1 on the same edge -> count=0, ovf=1; then clr_flags alone -> ovf=0.
REQ-035 The bench SHALL cover: rst=1 and load=1 on the same edge while counting at 7 -> count=0, flags 0; load ignored.
REQ-036 The bench SHALL cover: MODULUS=16, SATURATE=0, down from 0 -> 15; enable=0 for 3 cycles -> count holds 15, tc=0.
